// File: rtl/ysyx_22041412_mdu_pkg.sv
// Shared definitions for the RV64M multiply/divide unit.
//   - funct3 encodings of the M-extension operations
//   - FSM state type
//   - sext32: sign-extend a 32-bit value to 64 bits
package ysyx_22041412_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } mdu_state_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22041412_mdu_if.sv
// Request/response bundle of the multiply/divide unit.
//   master: the EXU side, drives requests, flush and out_ready
//   slave : the MDU, drives in_ready, out_valid, result and busy
interface ysyx_22041412_mdu_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      func3;
  logic            rv64w;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, func3, rv64w, rs1, rs2, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, func3, rv64w, rs1, rs2, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/ysyx_22041412_mdu_div.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               abandon the running division
//   start               load operands and begin (one-cycle pulse)
//   is_w                32-bit division (32 iterations) instead of XLEN
//   dividend, divisor   unsigned magnitudes; upper half zero when is_w
//   quotient, remainder magnitudes after the current step; final when done=1
//   done                high in the cycle whose closing edge retires the last bit
module ysyx_22041412_mdu_div #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic            is_w,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic            active_q;
  logic            is_w_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;  // dividend bits shift out the top, quotient bits in at the bottom
  logic [XLEN-1:0] dsr_q;

  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    trial     = rem_shift - {1'b0, dsr_q};
    ge        = ~trial[XLEN];
    rem_next  = ge ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_next  = {quo_q[XLEN-2:0], ge};
  end

  assign quotient  = quo_next;
  assign remainder = rem_next;
  assign done      = active_q && (cnt_q == (is_w_q ? CntW'(31) : CntW'(XLEN - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      is_w_q   <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
    end else if (flush) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      is_w_q   <= is_w;
      cnt_q    <= '0;
      rem_q    <= '0;
      // W divides align the 32-bit dividend to the top so its MSB shifts out first
      quo_q    <= is_w ? (dividend << (XLEN - 32)) : dividend;
      dsr_q    <= divisor;
    end else if (active_q) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q + CntW'(1);
      if (done) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ysyx_22041412_mdu.sv
// Multi-cycle RV64M multiply/divide unit.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         slave side of ysyx_22041412_mdu_if: request handshake
//               (in_valid/in_ready, func3, rv64w, rs1, rs2), flush,
//               result handshake (out_valid/out_ready, result) and busy.
// Multiplication is an iterative shift-add on magnitudes, MUL_BPC bits per
// cycle; division uses ysyx_22041412_mdu_div. Sign fixup happens here on
// the final compute edge so the result lands in DONE on that same edge.
// XLEN must be 64 whenever W operations are issued.
module ysyx_22041412_mdu
  import ysyx_22041412_mdu_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned MUL_BPC = 4
) (
  input logic                clk,
  input logic                rst_n,
  ysyx_22041412_mdu_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(XLEN);
  localparam logic [CntW-1:0] MulLast  = CntW'(XLEN / MUL_BPC - 1);
  localparam logic [CntW-1:0] MulLastW = CntW'(32 / MUL_BPC - 1);

  mdu_state_e      state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [XLEN-1:0] result_q;

  // Latched operation context
  logic              op_w_q;
  logic              op_hi_q;
  logic              op_rem_q;
  logic              neg_q;
  logic              rem_neg_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [2*XLEN-1:0] prod_q;
  logic [CntW-1:0]   cnt_q;

  // ---------------------------------------------------------------------------
  // Request decode (valid while a request sits on the bus in IDLE)
  // ---------------------------------------------------------------------------
  logic            op_div;
  logic            op_rem;
  logic            op_hi;
  logic            s1;
  logic            s2;
  logic            illegal;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] min_val;
  logic [XLEN-1:0] rem_src;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            accept;

  always_comb begin
    op_div  = bus.func3 inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    op_rem  = bus.func3 inside {MDU_REM, MDU_REMU};
    op_hi   = bus.func3 != MDU_MUL;
    illegal = bus.rv64w && (bus.func3 inside {MDU_MULH, MDU_MULHSU, MDU_MULHU});
    if (op_div) begin
      s1 = bus.func3 inside {MDU_DIV, MDU_REM};
      s2 = s1;
    end else begin
      s1 = bus.func3 != MDU_MULHU;
      s2 = bus.func3 inside {MDU_MUL, MDU_MULH};
    end

    if (bus.rv64w) begin
      a_ext   = s1 ? XLEN'(sext32(bus.rs1[31:0])) : XLEN'({32'b0, bus.rs1[31:0]});
      b_ext   = s2 ? XLEN'(sext32(bus.rs2[31:0])) : XLEN'({32'b0, bus.rs2[31:0]});
      min_val = XLEN'(sext32(32'h8000_0000));
      rem_src = XLEN'(sext32(bus.rs1[31:0]));
    end else begin
      a_ext   = bus.rs1;
      b_ext   = bus.rs2;
      min_val = {1'b1, {(XLEN - 1){1'b0}}};
      rem_src = bus.rs1;
    end

    a_neg = s1 && a_ext[XLEN-1];
    b_neg = s2 && b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;

    div_zero = op_div && (b_ext == '0);
    div_ovf  = op_div && s1 && (a_ext == min_val) && (b_ext == '1);
    special  = illegal || div_zero || div_ovf;

    if (illegal) begin
      special_res = '0;
    end else if (div_zero) begin
      special_res = op_rem ? rem_src : '1;
    end else begin
      special_res = op_rem ? '0 : a_ext;
    end
  end

  assign accept = (state_q == StIdle) && bus.in_valid && !bus.flush;

  // ---------------------------------------------------------------------------
  // Multiplier step and fixup
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] partial;
  logic [2*XLEN-1:0] prod_next;
  logic [2*XLEN-1:0] prod_signed;
  logic              mul_last;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < MUL_BPC; i++) begin
      if (mplier_q[i]) begin
        partial = partial + (mcand_q << i);
      end
    end
    prod_next   = prod_q + partial;
    prod_signed = neg_q ? -prod_next : prod_next;
    mul_last    = cnt_q == (op_w_q ? MulLastW : MulLast);
    if (op_hi_q) begin
      mul_res = prod_signed[2*XLEN-1:XLEN];
    end else if (op_w_q) begin
      mul_res = XLEN'(sext32(prod_signed[31:0]));
    end else begin
      mul_res = prod_signed[XLEN-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Divider and fixup
  // ---------------------------------------------------------------------------
  logic            div_done;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] div_sel;
  logic [XLEN-1:0] div_res;

  ysyx_22041412_mdu_div #(
    .XLEN(XLEN)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.flush),
    .start    (accept && op_div && !special),
    .is_w     (bus.rv64w),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quotient (div_quo),
    .remainder(div_rem),
    .done     (div_done)
  );

  always_comb begin
    quo_fix = neg_q ? -div_quo : div_quo;
    rem_fix = rem_neg_q ? -div_rem : div_rem;
    div_sel = op_rem_q ? rem_fix : quo_fix;
    div_res = op_w_q ? XLEN'(sext32(div_sel[31:0])) : div_sel;
  end

  // ---------------------------------------------------------------------------
  // Operand / accumulator registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_w_q    <= 1'b0;
      op_hi_q   <= 1'b0;
      op_rem_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      op_w_q    <= bus.rv64w;
      op_hi_q   <= op_hi;
      op_rem_q  <= op_rem;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      mcand_q   <= {{XLEN{1'b0}}, a_mag};
      mplier_q  <= b_mag;
      prod_q    <= '0;
      cnt_q     <= '0;
    end else if (state_q == StMul) begin
      prod_q   <= prod_next;
      mcand_q  <= mcand_q << MUL_BPC;
      mplier_q <= mplier_q >> MUL_BPC;
      cnt_q    <= cnt_q + CntW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else if (bus.flush) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (special) begin
              state_q     <= StDone;
              result_q    <= special_res;
              out_valid_q <= 1'b1;
            end else if (op_div) begin
              state_q <= StDiv;
            end else begin
              state_q <= StMul;
            end
          end
        end
        StMul: begin
          if (mul_last) begin
            state_q     <= StDone;
            result_q    <= mul_res;
            out_valid_q <= 1'b1;
          end
        end
        StDiv: begin
          if (div_done) begin
            state_q     <= StDone;
            result_q    <= div_res;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_ysyx_22041412_mdu.sv
module tb_ysyx_22041412_mdu;
  import ysyx_22041412_mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ysyx_22041412_mdu_if #(.XLEN(64)) bus ();

  ysyx_22041412_mdu #(
    .XLEN   (64),
    .MUL_BPC(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, expect out_valid exactly lat edges after acceptance, check result.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat);
    int n;
    logic [63:0] e;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func3    = f3;
    bus.rv64w    = w;
    bus.rs1      = a;
    bus.rs2      = b;
    sb.push_back(exp);
    @(posedge clk); #1;  // acceptance edge T
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    e = sb.pop_front();
    check(tag, bus.result, e);
  endtask

  task automatic finish_hs(input string tag);
    @(posedge clk); #1;
    check({tag, "_inrdy"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_ovld"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    logic [63:0] held;
    bus.in_valid  = 1'b0;
    bus.func3     = 3'b000;
    bus.rv64w     = 1'b0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_inrdy", 64'(bus.in_ready), 64'd1);
    check("rst_ovld", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_res", bus.result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mul", MDU_MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 16);
    finish_hs("mul");
    do_op("mulhu", MDU_MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 16);
    finish_hs("mulhu");
    do_op("mulhsu", MDU_MULHSU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 16);
    do_op("mulh", MDU_MULH, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 16);
    do_op("div", MDU_DIV, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64);
    finish_hs("div");
    do_op("rem", MDU_REM, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    do_op("remu", MDU_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 64);
    do_op("divu0", MDU_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    finish_hs("divu0");
    do_op("removf", MDU_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 0);
    do_op("divuw", MDU_DIVU, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 32);
    do_op("mulw", MDU_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 8);
    do_op("remw", MDU_REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd4, 64'hFFFF_FFFF_FFFF_FFFD, 32);
    finish_hs("remw");

    // Request together with flush in IDLE is ignored
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    bus.func3    = MDU_DIV;
    bus.rv64w    = 1'b0;
    bus.rs1      = 64'd9;
    bus.rs2      = 64'd3;
    @(posedge clk); #1;
    check("flidle_busy", 64'(bus.busy), 64'd0);
    check("flidle_inrdy", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;

    // Flush DIV at T+10
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;  // T
    bus.in_valid = 1'b0;
    check("fl_busy_run", 64'(bus.busy), 64'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;  // T+10
    bus.flush = 1'b0;
    check("fl_inrdy", 64'(bus.in_ready), 64'd1);
    check("fl_busy", 64'(bus.busy), 64'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("fl_noresult", 64'(seen), 64'd0);

    // Hold result in DONE with out_ready low
    bus.out_ready = 1'b0;
    do_op("hold", MDU_MULHU, 1'b0, 64'h0000_0001_0000_0000, 64'h0000_0003_0000_0000,
          64'd3, 16);
    held = bus.result;
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_res", bus.result, 64'd3);
      check("hold_inrdy", 64'(bus.in_ready), 64'd0);
      check("hold_ovld", 64'(bus.out_valid), 64'd1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    finish_hs("hold");
    check("hold_after", bus.result, held);

    // Reset mid-operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func3    = MDU_MUL;
    bus.rs1      = 64'd7;
    bus.rs2      = 64'd6;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_inrdy", 64'(bus.in_ready), 64'd1);
    check("mrst_res", bus.result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("mrst_noresult", 64'(seen), 64'd0);

    do_op("post_rst", MDU_MUL, 1'b0, 64'd7, 64'd6, 64'd42, 16);
    finish_hs("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
